bus_arbiter: RTL and testbench

Sequencing controller for the MCU's shared tristate internal data bus. It grants bus ownership to one of N requesters at a time using round-robin priority. It drives the per-source output-enable lines into the tristate bus buffers (`c` input of each buffer; enable high drives, low floats Z). Every handover inserts one turnaround cycle with all enables low, so two buffers never drive the bus at once.

---
 rtl/bus_arbiter_if.sv | 41 ++++
 rtl/bus_arbiter.sv | 114 +++++++++++
 tb/tb_bus_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Bus arbitration interface: requester levels in, tristate drive enables
// and ownership status out.
//   req   : level request per source, held while the source needs the bus
//   oe    : one-hot-or-zero output enables to the tristate bus buffers
//   gnt   : grant per requester, always equal to oe
//   owner : index of the current owner while busy, else 0
//   busy  : a source currently owns the bus
//   turn  : turnaround cycle, all enables low
// master = arbiter side, slave = requester/observer side.
// Handshake: a source keeps req high for as long as it needs the bus. It may
// drive only while its gnt bit is high. Dropping req is the release.
interface bus_arbiter_if #(
  parameter int N = 4
) ();
  localparam int OW = $clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  oe;
  logic [N-1:0]  gnt;
  logic [OW-1:0] owner;
  logic          busy;
  logic          turn;

  modport master (
    input  req,
    output oe,
    output gnt,
    output owner,
    output busy,
    output turn
  );

  modport slave (
    output req,
    input  oe,
    input  gnt,
    input  owner,
    input  busy,
    input  turn
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared tristate internal data bus.
// It drives the per-source output enables of the bus buffers. Every change
// of owner passes through one TURN cycle with all enables low, so two
// buffers never drive the bus at the same time.
// Ports:
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : bus_arbiter_if master modport (req in; oe/gnt/owner/busy/turn out)
//   dbg_state : current FSM state (0 IDLE, 1 OWN, 2 TURN)
module bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.master bus,
  output logic [1:0]    dbg_state
);
  localparam int OW = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN  = 2'd1;
  localparam logic [1:0] S_TURN = 2'd2;

  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [7:0]   HOLD_TOP = 8'(MAX_HOLD - 1);

  logic [1:0]    state_q;
  logic [N-1:0]  oe_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] ptr_q;
  logic [7:0]    hold_q;

  // Round-robin search starting at ptr_q, wrapping modulo N.
  logic          found;
  logic [OW-1:0] win;

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && bus.req[(int'(ptr_q) + i) % N]) begin
        found = 1'b1;
        win   = OW'((int'(ptr_q) + i) % N);
      end
    end
  end

  // The exit test uses only the owner's req bit and the OR of the others.
  logic [N-1:0]  owner_mask;
  logic          owner_req;
  logic          others_req;
  logic          own_exit;
  logic [OW-1:0] ptr_next;

  always_comb begin
    owner_mask = ONE << owner_q;
    owner_req  = |(bus.req & owner_mask);
    others_req = |(bus.req & ~owner_mask);
    own_exit   = !owner_req || ((hold_q == HOLD_TOP) && others_req);
    ptr_next   = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      oe_q    <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_TURN: begin
          if (found) begin
            state_q <= S_OWN;
            oe_q    <= ONE << win;
            owner_q <= win;
            hold_q  <= '0;
          end else begin
            state_q <= S_IDLE;
            oe_q    <= '0;
            owner_q <= '0;
          end
        end
        S_OWN: begin
          if (own_exit) begin
            // The old owner gets the lowest priority in the next search.
            state_q <= S_TURN;
            oe_q    <= '0;
            owner_q <= '0;
            ptr_q   <= ptr_next;
            hold_q  <= '0;
          end else if (hold_q != HOLD_TOP) begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          oe_q    <= '0;
          owner_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    bus.oe    = oe_q;
    bus.gnt   = oe_q;
    bus.owner = owner_q;
    bus.busy  = (state_q == S_OWN);
    bus.turn  = (state_q == S_TURN);
    dbg_state = state_q;
  end
endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  int tests_run;
  int tests_failed;

  logic [1:0] exp_q[$];

  bus_arbiter_if #(.N(N)) bus_if ();

  bus_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance one clock; afterwards sit 2 time units past the edge, where
  // outputs are sampled and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    bus_if.req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits for a non-zero oe, bounded; g is 0 on timeout.
  task automatic wait_grant(output logic [3:0] g, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (bus_if.oe == 4'b0000 && waited < 32);
    g = bus_if.oe;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [1:0] e;
    rst_n      = 1'b0;
    bus_if.req = 4'b1111;
    tick();
    tick();
    tests_run++;
    if (bus_if.oe !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_oe: got %b expected 0000", bus_if.oe);
    end
    tests_run++;
    if (bus_if.gnt !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_gnt: got %b expected 0000", bus_if.gnt);
    end
    tests_run++;
    if (bus_if.busy !== 1'b0 || bus_if.turn !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy_turn: got busy=%b turn=%b expected 0 0", bus_if.busy, bus_if.turn);
    end
    tests_run++;
    if (bus_if.owner !== 2'd0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_owner_state: got owner=%0d state=%0d expected 0 0", bus_if.owner, dbg_state);
    end
    rst_n = 1'b1;
    exp_q.push_back(2'd0);
    tick();
    e = exp_q.pop_front();
    tests_run++;
    if (bus_if.oe !== (4'b0001 << e) || bus_if.owner !== e) begin
      tests_failed++;
      $display("FAIL reset_first_grant: got oe=%b owner=%0d expected oe=%b owner=%0d",
               bus_if.oe, bus_if.owner, 4'b0001 << e, e);
    end
    bus_if.req = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    logic [1:0] e;
    do_reset();
    bus_if.req = 4'b0100;
    exp_q.push_back(2'd2);
    tick();
    e = exp_q.pop_front();
    for (int c = 0; c < 20; c++) begin
      tests_run++;
      if (bus_if.oe !== (4'b0001 << e) || bus_if.gnt !== bus_if.oe || bus_if.owner !== e) begin
        tests_failed++;
        $display("FAIL single_hold cycle %0d: got oe=%b gnt=%b owner=%0d expected oe=%b owner=%0d",
                 c + 1, bus_if.oe, bus_if.gnt, bus_if.owner, 4'b0001 << e, e);
      end
      if (c == 19) bus_if.req = 4'b0000;
      tick();
    end
    tests_run++;
    if (bus_if.turn !== 1'b1 || bus_if.oe !== 4'b0000 || bus_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_turn: got turn=%b oe=%b busy=%b expected 1 0000 0",
               bus_if.turn, bus_if.oe, bus_if.busy);
    end
    tick();
    tests_run++;
    if (bus_if.turn !== 1'b0 || bus_if.oe !== 4'b0000 || bus_if.busy !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL single_idle: got turn=%b oe=%b busy=%b state=%0d expected 0 0000 0 0",
               bus_if.turn, bus_if.oe, bus_if.busy, dbg_state);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [1:0] e;
    int         w;
    int         n;
    do_reset();
    bus_if.req = 4'b1111;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    for (int k = 0; k < 5; k++) begin
      wait_grant(g, w);
      e = exp_q.pop_front();
      tests_run++;
      if (g !== (4'b0001 << e) || w != 1) begin
        tests_failed++;
        $display("FAIL rr_grant %0d: got oe=%b after %0d cycles expected oe=%b after 1",
                 k, g, w, 4'b0001 << e);
      end
      if (k < 4) begin
        n = 0;
        while (bus_if.oe === g && n < 40) begin
          n++;
          tick();
        end
        tests_run++;
        if (n != MAX_HOLD) begin
          tests_failed++;
          $display("FAIL rr_hold %0d: got %0d cycles expected %0d", k, n, MAX_HOLD);
        end
        tests_run++;
        if (bus_if.turn !== 1'b1 || bus_if.oe !== 4'b0000) begin
          tests_failed++;
          $display("FAIL rr_turn %0d: got turn=%b oe=%b expected 1 0000", k, bus_if.turn, bus_if.oe);
        end
      end
    end
    bus_if.req = '0;
    tick();
    tick();
  endtask

  task automatic test_early_release(input logic [3:0] r, input logic [1:0] first,
                                    input logic [1:0] second);
    logic [3:0] g;
    logic [1:0] e;
    int         w;
    do_reset();
    bus_if.req = r;
    exp_q.push_back(first);
    exp_q.push_back(second);
    wait_grant(g, w);
    e = exp_q.pop_front();
    tests_run++;
    if (g !== (4'b0001 << e)) begin
      tests_failed++;
      $display("FAIL early_first req=%b: got oe=%b expected %b", r, g, 4'b0001 << e);
    end
    tick();
    tick();
    tests_run++;
    if (bus_if.oe !== (4'b0001 << e)) begin
      tests_failed++;
      $display("FAIL early_hold req=%b: got oe=%b expected %b", r, bus_if.oe, 4'b0001 << e);
    end
    bus_if.req = r & ~(4'b0001 << first);
    tick();
    tests_run++;
    if (bus_if.turn !== 1'b1 || bus_if.oe !== 4'b0000) begin
      tests_failed++;
      $display("FAIL early_turn req=%b: got turn=%b oe=%b expected 1 0000", r, bus_if.turn, bus_if.oe);
    end
    wait_grant(g, w);
    e = exp_q.pop_front();
    tests_run++;
    if (g !== (4'b0001 << e) || w != 1) begin
      tests_failed++;
      $display("FAIL early_next req=%b: got oe=%b after %0d cycles expected %b after 1",
               r, g, w, 4'b0001 << e);
    end
    bus_if.req = '0;
    tick();
    tick();
  endtask

  task automatic test_async_reset();
    logic [1:0] e;
    do_reset();
    bus_if.req = 4'b0001;
    tick();
    bus_if.req = 4'b0010;
    tick();
    tick();
    tests_run++;
    if (bus_if.oe !== 4'b0010) begin
      tests_failed++;
      $display("FAIL async_setup: got oe=%b expected 0010", bus_if.oe);
    end
    bus_if.req = 4'b0011;
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.oe !== 4'b0000 || bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b0 ||
        bus_if.turn !== 1'b0 || dbg_state !== 2'd0) begin
      tests_failed++;
      $display("FAIL async_clear: got oe=%b gnt=%b busy=%b turn=%b state=%0d expected 0000 0000 0 0 0",
               bus_if.oe, bus_if.gnt, bus_if.busy, bus_if.turn, dbg_state);
    end
    #2;
    rst_n = 1'b1;
    exp_q.push_back(2'd0);
    tick();
    e = exp_q.pop_front();
    tests_run++;
    if (bus_if.oe !== (4'b0001 << e)) begin
      tests_failed++;
      $display("FAIL async_ptr: got oe=%b expected %b", bus_if.oe, 4'b0001 << e);
    end
    bus_if.req = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [3:0] prev;
    do_reset();
    prev = '0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) bus_if.req = 4'($urandom_range(0, 15));
      tick();
      tests_run++;
      if (!$onehot0(bus_if.oe) || bus_if.gnt !== bus_if.oe) begin
        tests_failed++;
        $display("FAIL rand_onehot cycle %0d: got oe=%b gnt=%b expected one-hot-or-zero, equal",
                 c, bus_if.oe, bus_if.gnt);
      end
      tests_run++;
      if (prev != 4'b0000 && bus_if.oe != 4'b0000 && bus_if.oe != prev) begin
        tests_failed++;
        $display("FAIL rand_overlap cycle %0d: got oe %b -> %b expected a zero cycle between",
                 c, prev, bus_if.oe);
      end
      tests_run++;
      if ((bus_if.busy && bus_if.turn) ||
          (bus_if.busy && bus_if.oe !== (4'b0001 << bus_if.owner)) ||
          (!bus_if.busy && (bus_if.oe !== 4'b0000 || bus_if.owner !== 2'd0))) begin
        tests_failed++;
        $display("FAIL rand_status cycle %0d: got busy=%b turn=%b oe=%b owner=%0d expected consistent",
                 c, bus_if.busy, bus_if.turn, bus_if.oe, bus_if.owner);
      end
      prev = bus_if.oe;
    end
    bus_if.req = '0;
    tick();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    bus_if.req   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_early_release(4'b1010, 2'd1, 2'd3);
    test_early_release(4'b1110, 2'd1, 2'd2);
    test_async_reset();
    test_random();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
